// File: rtl/bg_tile_fetcher.sv
// Background tile fetch engine: walks one scanline of tile columns, reads map index and
// both bitplane bytes over VRAM port A, and hands each row to the pixel FIFO.
module bg_tile_fetcher #(
    parameter int unsigned TILES_PER_LINE = 21,
    parameter logic [12:0] MAP0_BASE      = 13'h1800,
    parameter logic [12:0] MAP1_BASE      = 13'h1C00
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  ly,
    input  logic [7:0]  scx,
    input  logic [7:0]  scy,
    input  logic        lcdc_map_sel,
    input  logic        lcdc_data_sel,
    output logic [12:0] vram_addrA,
    input  logic [7:0]  vram_outA,
    output logic [7:0]  row_lo,
    output logic [7:0]  row_hi,
    output logic        row_valid,
    input  logic        row_ready,
    output logic        busy,
    output logic        line_done
);

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TX_W   = $clog2(TILES_PER_LINE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP_ADDR,
        S_MAP_LATCH,
        S_LO_ADDR,
        S_LO_LATCH,
        S_HI_ADDR,
        S_HI_LATCH,
        S_PUSH
    } state_t;

    // Tile-map byte address for a given map row/column.
    function automatic logic [ADDR_W-1:0] map_addr_f(input logic       sel,
                                                     input logic [4:0] row,
                                                     input logic [4:0] col);
        return (sel ? MAP1_BASE : MAP0_BASE) + {3'b000, row, col};
    endfunction

    // Low-bitplane address of one tile row; signed mode indexes around 0x1000.
    function automatic logic [ADDR_W-1:0] tile_addr_f(input logic [DATA_W-1:0] idx,
                                                      input logic              unsigned_mode,
                                                      input logic [2:0]        fy);
        logic [ADDR_W-1:0] base;
        if (unsigned_mode) begin
            base = {1'b0, idx, 4'b0000};
        end else begin
            base = 13'h1000 + {idx[7], idx, 4'b0000};
        end
        return base + {9'd0, fy, 1'b0};
    endfunction

    state_t              state_q, state_d;
    logic [TX_W-1:0]     tile_x_q, tile_x_d;
    logic [2:0]          fine_y_q, fine_y_d;
    logic [4:0]          map_row_q, map_row_d;
    logic [4:0]          scx_col_q, scx_col_d;
    logic                map_sel_q, map_sel_d;
    logic                data_sel_q, data_sel_d;
    logic [DATA_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   row_lo_q, row_lo_d;
    logic [DATA_W-1:0]   row_hi_q, row_hi_d;
    logic                row_valid_q, row_valid_d;
    logic                busy_q, busy_d;
    logic                line_done_q, line_done_d;

    logic [7:0]          line_y;
    logic [TX_W-1:0]     tile_x_inc;
    logic [4:0]          next_col;
    logic                last_tile;
    logic                unused_scx_fine;

    assign line_y          = ly + scy;
    assign tile_x_inc      = tile_x_q + TX_W'(1);
    assign next_col        = scx_col_q + 5'(tile_x_inc);
    assign last_tile       = (tile_x_q == TX_W'(TILES_PER_LINE - 1));
    // Fine X scroll is applied downstream in the pixel FIFO.
    assign unused_scx_fine = ^scx[2:0];

    // Next-state and registered-output logic; abort overrides every transition.
    always_comb begin
        state_d     = state_q;
        tile_x_d    = tile_x_q;
        fine_y_d    = fine_y_q;
        map_row_d   = map_row_q;
        scx_col_d   = scx_col_q;
        map_sel_d   = map_sel_q;
        data_sel_d  = data_sel_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        row_lo_d    = row_lo_q;
        row_hi_d    = row_hi_q;
        row_valid_d = row_valid_q;
        line_done_d = 1'b0;

        if (abort) begin
            state_d     = S_IDLE;
            tile_x_d    = '0;
            row_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_MAP_ADDR;
                        tile_x_d   = '0;
                        fine_y_d   = line_y[2:0];
                        map_row_d  = line_y[7:3];
                        scx_col_d  = scx[7:3];
                        map_sel_d  = lcdc_map_sel;
                        data_sel_d = lcdc_data_sel;
                        addr_d     = map_addr_f(lcdc_map_sel, line_y[7:3], scx[7:3]);
                    end
                end
                S_MAP_ADDR: state_d = S_MAP_LATCH;
                S_MAP_LATCH: begin
                    idx_d   = vram_outA;
                    addr_d  = tile_addr_f(vram_outA, data_sel_q, fine_y_q);
                    state_d = S_LO_ADDR;
                end
                S_LO_ADDR: state_d = S_LO_LATCH;
                S_LO_LATCH: begin
                    row_lo_d = vram_outA;
                    addr_d   = tile_addr_f(idx_q, data_sel_q, fine_y_q) + 13'd1;
                    state_d  = S_HI_ADDR;
                end
                S_HI_ADDR: state_d = S_HI_LATCH;
                S_HI_LATCH: begin
                    row_hi_d    = vram_outA;
                    row_valid_d = 1'b1;
                    state_d     = S_PUSH;
                end
                S_PUSH: begin
                    if (row_ready) begin
                        row_valid_d = 1'b0;
                        if (last_tile) begin
                            line_done_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            tile_x_d = tile_x_inc;
                            addr_d   = map_addr_f(map_sel_q, map_row_q, next_col);
                            state_d  = S_MAP_ADDR;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            tile_x_q    <= '0;
            fine_y_q    <= '0;
            map_row_q   <= '0;
            scx_col_q   <= '0;
            map_sel_q   <= 1'b0;
            data_sel_q  <= 1'b0;
            idx_q       <= '0;
            addr_q      <= '0;
            row_lo_q    <= '0;
            row_hi_q    <= '0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_x_q    <= tile_x_d;
            fine_y_q    <= fine_y_d;
            map_row_q   <= map_row_d;
            scx_col_q   <= scx_col_d;
            map_sel_q   <= map_sel_d;
            data_sel_q  <= data_sel_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            row_lo_q    <= row_lo_d;
            row_hi_q    <= row_hi_d;
            row_valid_q <= row_valid_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
        end
    end

    assign vram_addrA = addr_q;
    assign row_lo     = row_lo_q;
    assign row_hi     = row_hi_q;
    assign row_valid  = row_valid_q;
    assign busy       = busy_q;
    assign line_done  = line_done_q;

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Bench for bg_tile_fetcher: synchronous VRAM model plus an arithmetic reference
// of the map/tile address rules, driven by directed and randomized scanlines.
module tb_bg_tile_fetcher;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [7:0]  ly;
    logic [7:0]  scx;
    logic [7:0]  scy;
    logic        lcdc_map_sel;
    logic        lcdc_data_sel;
    logic [12:0] vram_addrA;
    logic [7:0]  vram_outA;
    logic [7:0]  row_lo;
    logic [7:0]  row_hi;
    logic        row_valid;
    logic        row_ready;
    logic        busy;
    logic        line_done;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:8191];

    bg_tile_fetcher dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .ly           (ly),
        .scx          (scx),
        .scy          (scy),
        .lcdc_map_sel (lcdc_map_sel),
        .lcdc_data_sel(lcdc_data_sel),
        .vram_addrA   (vram_addrA),
        .vram_outA    (vram_outA),
        .row_lo       (row_lo),
        .row_hi       (row_hi),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .busy         (busy),
        .line_done    (line_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read VRAM: data appears one cycle after the address.
    always @(posedge clock) vram_outA <= mem[vram_addrA];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_map(int lyv, int scxv, int scyv, int msel, int t);
        int y;
        y = (lyv + scyv) % 256;
        return (msel != 0 ? 'h1C00 : 'h1800) + (y / 8) * 32 + ((scxv / 8 + t) % 32);
    endfunction

    function automatic int m_lo(int idx, int dsel, int fine);
        int b;
        if (dsel != 0) b = idx * 16;
        else           b = 4096 + (idx >= 128 ? idx - 256 : idx) * 16;
        return (b + fine * 2) % 8192;
    endfunction

    task automatic drive_cfg(input int lyv, input int scxv, input int scyv, input int msel, input int dsel);
        ly            = 8'(lyv);
        scx           = 8'(scxv);
        scy           = 8'(scyv);
        lcdc_map_sel  = 1'(msel);
        lcdc_data_sel = 1'(dsel);
    endtask

    // One full scanline; k_* >= 0 adds hand-computed checks on tile 0.
    task automatic run_line(input int lyv, input int scxv, input int scyv, input int msel,
                            input int dsel, input int stall_t, input int stall_n,
                            input int k_map0, input int k_lo0);
        int fine, ma, la, idx;
        fine = ((lyv + scyv) % 256) % 8;
        @(negedge clock);
        drive_cfg(lyv, scxv, scyv, msel, dsel);
        start     = 1'b1;
        row_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drive_cfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        for (int t = 0; t < 21; t++) begin
            ma  = m_map(lyv, scxv, scyv, msel, t);
            idx = int'(mem[ma]);
            la  = m_lo(idx, dsel, fine);
            chk($sformatf("map_addr t%0d", t), vram_addrA, ma);
            chk($sformatf("busy t%0d", t), busy, 1);
            if (t == 0 && k_map0 >= 0) chk("map_addr_const", vram_addrA, k_map0);
            repeat (2) @(negedge clock);
            chk($sformatf("lo_addr t%0d", t), vram_addrA, la);
            chk($sformatf("early_valid t%0d", t), row_valid, 0);
            if (t == 0 && k_lo0 >= 0) chk("lo_addr_const", vram_addrA, k_lo0);
            repeat (2) @(negedge clock);
            chk($sformatf("hi_addr t%0d", t), vram_addrA, la + 1);
            if (t == 0 && k_lo0 >= 0) chk("hi_addr_const", vram_addrA, k_lo0 + 1);
            repeat (2) @(negedge clock);
            chk($sformatf("row_valid t%0d", t), row_valid, 1);
            chk($sformatf("row_lo t%0d", t), row_lo, mem[la]);
            chk($sformatf("row_hi t%0d", t), row_hi, mem[la + 1]);
            if (t == stall_t) begin
                row_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clock);
                    chk($sformatf("stall_valid t%0d s%0d", t, s), row_valid, 1);
                    chk($sformatf("stall_lo t%0d s%0d", t, s), row_lo, mem[la]);
                    chk($sformatf("stall_hi t%0d s%0d", t, s), row_hi, mem[la + 1]);
                    chk($sformatf("stall_addr t%0d s%0d", t, s), vram_addrA, la + 1);
                end
                row_ready = 1'b1;
            end
            @(negedge clock);
        end
        chk("line_done_pulse", line_done, 1);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", row_valid, 0);
        @(negedge clock);
        chk("line_done_single", line_done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int ma;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        row_ready = 1'b0;
        drive_cfg(0, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        chk("rst_addr", vram_addrA, 0);
        chk("rst_lo", row_lo, 0);
        chk("rst_hi", row_hi, 0);
        chk("rst_valid", row_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", line_done, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed address cases, with a 5-cycle stall at tile 3 on the first line.
        mem[13'h1845] = 8'h05;
        run_line(5, 'h28, 'h10, 0, 0, 3, 5, 'h1845, 'h105A);
        mem[13'h1845] = 8'h96;
        run_line(5, 'h28, 'h10, 0, 0, -1, 0, 'h1845, 'h096A);
        mem[13'h1845] = 8'h05;
        run_line(5, 'h28, 'h10, 0, 1, -1, 0, 'h1845, 'h005A);
        mem[13'h1800] = 8'hFF;
        run_line(7, 0, 0, 0, 1, -1, 0, 'h1800, 'h0FFE);
        run_line(0, 'hF8, 0, 0, 0, -1, 0, 'h181F, -1);
        mem[13'h1800] = 8'h05;
        run_line(1, 0, 'hFF, 0, 1, -1, 0, 'h1800, 'h0050);
        run_line(0, 'h18, 0, 1, 0, -1, 0, 'h1C03, -1);

        for (int r = 0; r < 4; r++) begin
            run_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
                     int'($urandom_range(1, 6)), -1, -1);
        end

        // Abort during HI_LATCH, then restart the following cycle.
        @(negedge clock);
        drive_cfg(9, 'h40, 'h22, 1, 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        chk("abort_pre_valid", row_valid, 0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_hl_valid", row_valid, 0);
        chk("abort_hl_busy", busy, 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        ma = m_map(9, 'h40, 'h22, 1, 0);
        chk("restart_busy", busy, 1);
        chk("restart_addr", vram_addrA, ma);
        repeat (6) @(negedge clock);
        chk("push_valid", row_valid, 1);
        // Abort colliding with an accept in PUSH.
        abort     = 1'b1;
        row_ready = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_push_valid", row_valid, 0);
        chk("abort_push_done", line_done, 0);
        chk("abort_push_busy", busy, 0);
        // Abort beats a simultaneous start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        @(negedge clock);
        chk("abort_start_busy2", busy, 0);
        run_line(33, 'h9D, 'h71, 0, 0, 20, 3, -1, -1);

        // Asynchronous reset while a row waits in PUSH.
        @(negedge clock);
        drive_cfg(100, 'h55, 'h0F, 0, 1);
        start     = 1'b1;
        row_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        chk("prereset_valid", row_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_addr", vram_addrA, 0);
        chk("arst_lo", row_lo, 0);
        chk("arst_hi", row_hi, 0);
        chk("arst_valid", row_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", line_done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        run_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1, 1, 7, 2, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bg_tile_fetcher.md
Name: bg_tile_fetcher

Overview:
- Per-scanline background tile fetch engine for the GBC PPU.
- Sits directly upstream of the pixel FIFO and shares VRAM read port A.
- For each tile column it reads the tile-map index, computes the tile-data row address (signed or unsigned addressing per LCDC.4), then fetches the low and high bitplane bytes.
- Each completed row is handed to the FIFO over a valid/ready handshake.

Parameters:
- TILES_PER_LINE, 21, tile rows fetched per scanline: 20 visible plus 1 for fine-scroll spill.
- MAP0_BASE, 13'h1800, VRAM offset of tile map when LCDC.3=0.
- MAP1_BASE, 13'h1C00, VRAM offset of tile map when LCDC.3=1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins fetch for the current line.
- abort  in  1  synchronous; returns to IDLE immediately and drops any pending row.
- ly  in  8  current scanline.
- scx  in  8  background scroll X.
- scy  in  8  background scroll Y.
- lcdc_map_sel  in  1  LCDC.3.
- lcdc_data_sel  in  1  LCDC.4; 1 = unsigned at 0x0000, 0 = signed around 0x1000.
- vram_addrA  out  13  VRAM read address, byte offset from 0x8000.
- vram_outA  in  8  read data, valid exactly one cycle after vram_addrA is driven.
- row_lo  out  8  low bitplane byte.
- row_hi  out  8  high bitplane byte.
- row_valid  out  1  row_lo/row_hi are valid.
- row_ready  in  1  FIFO accepts the row on clock when row_valid && row_ready.
- busy  out  1  high in any state other than IDLE.
- line_done  out  1  one-cycle pulse after the last tile row is accepted.

Behaviour:
- Reset (reset_n low, async): state=IDLE, vram_addrA=0, row_lo=0, row_hi=0, row_valid=0, busy=0, line_done=0, tile counter=0.
- Latch: on start in IDLE, capture ly, scy, scx, lcdc_map_sel, lcdc_data_sel.
- Derived values (8-bit wrap):
  - y = ly+scy (mod 256); fine_y = y[2:0]; map_row = y[7:3].
  - map_col = (scx[7:3] + tile_x) mod 32, where tile_x is 0..TILES_PER_LINE-1.
  - map_addr = base + {map_row, map_col}; base = MAP1_BASE if lcdc_map_sel else MAP0_BASE.
  - Data base: unsigned mode = {1'b0, idx, 4'b0}; signed mode = 13'h1000 + sign_ext(idx)*16, computed in 13 bits with wrap.
  - lo_addr = data base + {fine_y, 1'b0}; hi_addr = lo_addr + 1.
- States:
  - IDLE -> (start) MAP_ADDR.
  - MAP_ADDR: drive map_addr -> MAP_LATCH.
  - MAP_LATCH: capture idx = vram_outA -> LO_ADDR.
  - LO_ADDR: drive lo_addr -> LO_LATCH.
  - LO_LATCH: capture row_lo -> HI_ADDR.
  - HI_ADDR: drive hi_addr -> HI_LATCH.
  - HI_LATCH: capture row_hi; set row_valid -> PUSH.
  - PUSH: hold row_valid and data until row_ready.
    - On accept: clear row_valid; if tile_x == TILES_PER_LINE-1, pulse line_done and go to IDLE; else tile_x+1 -> MAP_ADDR.
- Timing: minimum 7 cycles per tile with row_ready held high; first row_valid appears 6 cycles after the start pulse.
- Backpressure: row_lo/row_hi remain stable while row_valid && !row_ready.
- vram_addrA holds its last value in non-ADDR states.
- start outside IDLE is ignored.
- abort has priority over all transitions, including a simultaneous start or accept. On abort: row_valid=0, tile_x=0, no line_done. start in the cycle after abort is honoured.
- Register inputs changing mid-line have no effect until the next start.

Test Plan:
- Map address: scy=0x10, ly=5, scx=0x28, LCDC.3=0 -> first vram_addrA=0x1845; fine_y=5.
- Signed mode: LCDC.4=0, map byte 0x05, fine_y=5 -> lo_addr=0x105A, hi_addr=0x105B. With map byte 0x96 -> 0x096A/0x096B.
- Unsigned mode: LCDC.4=1, map byte 0x05 -> 0x005A/0x005B. With map byte 0xFF and fine_y=7 -> 0x0FFE/0x0FFF.
- Wrap:
  - scx=0xF8, tile_x=1 -> map_col=0.
  - scy=0xFF, ly=1 -> map_row=0, fine_y=0.
  - LCDC.3=1 -> first map address 0x1C00+col.
- Backpressure/line: row_ready low 5 cycles at tile 3 -> row_lo/row_hi held stable; full line gives 21 accepted rows, then a single line_done pulse; busy drops the same cycle.
- Abort/reset:
  - abort during HI_LATCH -> row_valid never asserts, state IDLE next cycle.
  - reset_n low in PUSH -> all outputs 0 asynchronously.
